// File: rtl/pio_ports.sv
// Z80-style parallel I/O: NPORTS 8-bit ports with per-bit direction, registered read data.
// Optional change-interrupt (mask/status, irq_n) built only when PIO_PORTS_IRQ_EN is defined.
module pio_ports #(
  parameter int          NPORTS    = 2,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [2:0]            addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic [NPORTS*8-1:0]   port_in,
  output logic [NPORTS*8-1:0]   port_out,
  output logic [NPORTS*8-1:0]   port_oe,
  output logic                  irq_n
);

  localparam int W = NPORTS * 8;

  logic           write_sel;
  logic           read_sel;
  logic           wr_pulse;
  // Holds "write_sel was low last clock"; reset to 0 so a strobe held across reset release is treated as already seen.
  logic           wr_idle_q;
  logic [W-1:0]   out_q;
  logic [W-1:0]   oe_q;
  logic [W-1:0]   sync1_q;
  logic [W-1:0]   sync2_q;
  logic [7:0]     data_out_d;
  logic [7:0]     data_out_q;

  assign write_sel = !cs_n && rd_n && !wr_n;
  assign read_sel  = !cs_n && !rd_n && wr_n;
  assign wr_pulse  = write_sel && wr_idle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idle_q  <= 1'b0;
      out_q      <= {NPORTS{RESET_VAL}};
      oe_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_out_q <= 8'hFF;
    end else begin
      wr_idle_q  <= !write_sel;
      sync1_q    <= port_in;
      sync2_q    <= sync1_q;
      data_out_q <= read_sel ? data_out_d : 8'hFF;
      for (int k = 0; k < NPORTS; k++) begin
        if (wr_pulse && addr == 3'(2 * k))     out_q[k*8 +: 8] <= data_in;
        if (wr_pulse && addr == 3'(2 * k + 1)) oe_q[k*8 +: 8]  <= data_in;
      end
    end
  end

`ifdef PIO_PORTS_IRQ_EN
  logic [NPORTS-1:0] mask_q;
  logic [NPORTS-1:0] status_q;
  logic [NPORTS-1:0] status_d;
  logic [NPORTS-1:0] chg;
  logic [1:0]        settle_q;
  logic              irq_n_q;

  // A change is seen as sync2 is about to take a new value, so status lands with the new sync2.
  always_comb begin
    chg      = '0;
    status_d = status_q;
    for (int k = 0; k < NPORTS; k++) begin
      chg[k] = |((sync1_q[k*8 +: 8] ^ sync2_q[k*8 +: 8]) & ~oe_q[k*8 +: 8]);
    end
    if (wr_pulse && addr == 3'd7) status_d = status_q & ~data_in[NPORTS-1:0];
    if (settle_q == 2'd2)         status_d = status_d | chg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= '0;
      status_q <= '0;
      settle_q <= 2'd0;
      irq_n_q  <= 1'b1;
    end else begin
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (wr_pulse && addr == 3'd6) mask_q <= data_in[NPORTS-1:0];
      status_q <= status_d;
      irq_n_q  <= !(|(status_q & mask_q));
    end
  end

  assign irq_n = irq_n_q;
`else
  assign irq_n = 1'b1;
`endif

  always_comb begin
    data_out_d = 8'hFF;
    for (int k = 0; k < NPORTS; k++) begin
      if (addr[2:1] == 2'(k)) begin
        data_out_d = addr[0] ? oe_q[k*8 +: 8]
                             : ((out_q[k*8 +: 8] & oe_q[k*8 +: 8]) |
                                (sync2_q[k*8 +: 8] & ~oe_q[k*8 +: 8]));
      end
    end
`ifdef PIO_PORTS_IRQ_EN
    if (addr == 3'd6) data_out_d = {{(8-NPORTS){1'b0}}, mask_q};
    if (addr == 3'd7) data_out_d = {{(8-NPORTS){1'b0}}, status_q};
`endif
  end

  assign data_out = data_out_q;
  assign port_out = out_q;
  assign port_oe  = oe_q;

endmodule

// File: tb/tb_pio_ports.sv
// Directed bench for pio_ports, NPORTS=2, RESET_VAL=8'h5A; IRQ checks follow PIO_PORTS_IRQ_EN.
module tb_pio_ports;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic [15:0] port_in = 16'h8001;
  logic [15:0] port_out;
  logic [15:0] port_oe;
  logic        irq_n;

  int n_vec = 0;
  int n_err = 0;

  pio_ports #(.NPORTS(2), .RESET_VAL(8'h5A)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .port_in(port_in), .port_out(port_out), .port_oe(port_oe), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // After the first edge data_in is inverted, so a repeated write would be visible.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    addr = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    data_in = ~d;
    repeat (hold - 1) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; data_in = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    d = data_out;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_port_out", port_out, 16'h5A5A);
    check("rst_port_oe", port_oe, 16'h0000);
    check("rst_data_out", {8'h00, data_out}, 16'h00FF);
    check("rst_irq_n", {15'd0, irq_n}, 16'h0001);

    // Long strobe: exactly one write.
    bus_write(3'd0, 8'hA5, 5);
    check("long_write", port_out, 16'h5AA5);

    // Mixed direction read on port 1.
    bus_write(3'd3, 8'hF0, 1);
    bus_write(3'd2, 8'h3C, 1);
    port_in = 16'h9A01;
    repeat (3) @(negedge clk);
    bus_read(3'd2, rd);
    check("mixed_read_p1", {8'h00, rd}, 16'h003A);
    bus_read(3'd3, rd);
    check("dir_read_p1", {8'h00, rd}, 16'h00F0);
    check("port_oe_p1", port_oe, 16'hF000);
    @(negedge clk);
    check("idle_data_out", {8'h00, data_out}, 16'h00FF);

    // All strobes low selects nothing.
    @(negedge clk);
    addr = 3'd0; data_in = 8'h00; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("both_low_data_out", {8'h00, data_out}, 16'h00FF);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    check("both_low_no_write", port_out, 16'h3CA5);

    // Nonexistent port 2.
    bus_write(3'd4, 8'h77, 1);
    bus_write(3'd5, 8'h77, 1);
    check("ghost_write_out", port_out, 16'h3CA5);
    check("ghost_write_oe", port_oe, 16'hF000);
    bus_read(3'd4, rd);
    check("ghost_read_4", {8'h00, rd}, 16'h00FF);
    bus_read(3'd5, rd);
    check("ghost_read_5", {8'h00, rd}, 16'h00FF);

    // Port 0 as input, then held read tracking the pins.
    port_in = 16'h9AC3;
    repeat (3) @(negedge clk);
    bus_read(3'd0, rd);
    check("input_read_p0", {8'h00, rd}, 16'h00C3);
    @(negedge clk);
    addr = 3'd0; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("held_read_a", {8'h00, data_out}, 16'h00C3);
    port_in = 16'h9A5E;
    repeat (3) @(negedge clk);
    check("held_read_b", {8'h00, data_out}, 16'h005E);
    cs_n = 1'b1; rd_n = 1'b1;

    bus_write(3'd1, 8'h0F, 1);
    bus_read(3'd0, rd);
    check("mixed_read_p0", {8'h00, rd}, 16'h0055);
    bus_write(3'd1, 8'h00, 1);

`ifdef PIO_PORTS_IRQ_EN
    bus_write(3'd7, 8'h03, 1);
    repeat (2) @(negedge clk);
    bus_read(3'd7, rd);
    check("status_cleared", {8'h00, rd}, 16'h0000);
    bus_write(3'd6, 8'h01, 1);
    bus_read(3'd6, rd);
    check("mask_read", {8'h00, rd}, 16'h0001);
    check("irq_idle", {15'd0, irq_n}, 16'h0001);
    port_in = port_in ^ 16'h0001;
    for (int i = 0; i < 4 && irq_n; i++) @(negedge clk);
    check("irq_asserted", {15'd0, irq_n}, 16'h0000);
    bus_read(3'd7, rd);
    check("status_p0", {8'h00, rd}, 16'h0001);
    bus_write(3'd7, 8'h01, 1);
    repeat (2) @(negedge clk);
    check("irq_cleared", {15'd0, irq_n}, 16'h0001);
    port_in = port_in ^ 16'h0100;
    repeat (4) @(negedge clk);
    check("irq_masked_p1", {15'd0, irq_n}, 16'h0001);
    bus_read(3'd7, rd);
    check("status_p1", {8'h00, rd}, 16'h0002);
`else
    bus_read(3'd6, rd);
    check("no_irq_read_6", {8'h00, rd}, 16'h00FF);
    bus_read(3'd7, rd);
    check("no_irq_read_7", {8'h00, rd}, 16'h00FF);
    bus_write(3'd6, 8'hFF, 1);
    port_in = port_in ^ 16'h0101;
    repeat (4) @(negedge clk);
    check("no_irq_pin", {15'd0, irq_n}, 16'h0001);
`endif

    // Reset in the middle of a held write.
    port_in = 16'h1234;
    @(negedge clk);
    addr = 3'd0; data_in = 8'h99; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("pre_reset_write", port_out, 16'h3C99);
    reset = 1'b1;
    data_in = 8'h66;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mid_write_out", port_out, 16'h5A5A);
    check("reset_mid_write_oe", port_oe, 16'h0000);
    cs_n = 1'b1; wr_n = 1'b1;
`ifdef PIO_PORTS_IRQ_EN
    bus_read(3'd7, rd);
    check("settle_no_status", {8'h00, rd}, 16'h0000);
`endif
    bus_write(3'd1, 8'h0F, 1);
    check("write_after_reset", port_oe, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
